// File: rtl/pll_reset_sequencer_if.sv
// Purpose: groups the PLL lock input, fault clear and reset/status outputs of the sequencer.
// Latency: none, wiring only.
// Backpressure: none, all signals are level or single-cycle strobes.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       lost_clr;
    logic       rst_core;
    logic       rst_periph;
    logic       ready;
    logic       tick;
    logic       lock_lost;
    logic [1:0] state;

    // Sequencer side: consumes lock and clear, drives resets and status.
    modport slave (
        input  pll_lock,
        input  lost_clr,
        output rst_core,
        output rst_periph,
        output ready,
        output tick,
        output lock_lost,
        output state
    );

    // Environment side: drives lock and clear, observes resets and status.
    modport master (
        output pll_lock,
        output lost_clr,
        input  rst_core,
        input  rst_periph,
        input  ready,
        input  tick,
        input  lock_lost,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Purpose: qualifies PLL lock, releases core then peripheral reset, generates a run-time tick.
// Latency: core reset released SYNC_STAGES+1+LOCK_STABLE_CYCLES edges after lock is first sampled.
// Backpressure: none; any lock drop immediately re-enters qualification.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PERIPH_DELAY       = 16,
    parameter int TICK_DIV           = 12000
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > PERIPH_DELAY) ? LOCK_STABLE_CYCLES : PERIPH_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TCNT_W  = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [TCNT_W-1:0] TICK_LAST   = TCNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABLE     = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   tick_q, tick_d;
    logic                   lost_q, lost_d;
    logic                   set_lost;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock synchroniser: the only place pll_lock is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
        end
    end

    // State, counters, tick strobe and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic; any lock drop returns to WAIT_LOCK, flagging a fault once the core is out of reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        set_lost = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL_PERIPH: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    set_lost = 1'b1;
                end else if (cnt_q == PERIPH_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    tcnt_d   = '0;
                    set_lost = 1'b1;
                end else if (tcnt_q == TICK_LAST) begin
                    tcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Tick qualified by live lock so it never fires on the edge that leaves RUN; set beats clear on the fault flag.
    always_comb begin
        tick_d = (state_q == RUN) && lock_s && (tcnt_q == TICK_LAST);
        if (set_lost) begin
            lost_d = 1'b1;
        end else if (bus.lost_clr) begin
            lost_d = 1'b0;
        end else begin
            lost_d = lost_q;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        bus.rst_core   = (state_q == WAIT_LOCK) || (state_q == STABLE);
        bus.rst_periph = (state_q != RUN);
        bus.ready      = (state_q == RUN);
        bus.tick       = tick_q;
        bus.lock_lost  = lost_q;
        bus.state      = state_q;
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed and randomized checking of pll_reset_sequencer against a lock-run-length model.
// Latency: inputs change on the falling edge, outputs are checked 1 time unit after each rising edge.
// Backpressure: none; every step is a fixed number of clock cycles.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int PD   = 4;
    localparam int TD   = 5;

    // Edge numbers with the first lock-sampling edge as edge 0; a value "at edge N" is the one presented to edge N.
    localparam int CORE_EDGE   = SYNC + 1 + LSC;
    localparam int PERIPH_EDGE = CORE_EDGE + PD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .PERIPH_DELAY      (PD),
        .TICK_DIV          (TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: q counts consecutive edges at which synchronised lock was seen high.
    // The phase (wait/stable/release/run) and tick position follow from q by arithmetic.
    int q = 0;
    bit m_sync [SYNC];
    bit m_lost = 1'b0;
    bit m_tick = 1'b0;

    function automatic int phase_of(input int qq);
        if (qq == 0)            return 0;
        else if (qq <= LSC)     return 1;
        else if (qq <= LSC + PD) return 2;
        else                    return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit lk, input bit clr);
        bit ls;
        int qb;
        if (r) begin
            q = 0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_lost = 1'b0;
            m_tick = 1'b0;
        end else begin
            ls = m_sync[SYNC-1];
            qb = q;
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = lk;
            q = ls ? q + 1 : 0;
            m_tick = ls && (qb > LSC + PD) && (((qb - LSC - PD - 1) % TD) == TD - 1);
            if (!ls && qb > LSC)
                m_lost = 1'b1;
            else if (clr)
                m_lost = 1'b0;
        end
    endtask

    // One clock: drive on falling edge, step the model on the rising edge, compare every output.
    task automatic cyc(input bit r, input bit lk, input bit clr);
        int ph;
        @(negedge clk);
        rst          = r;
        bus.pll_lock = lk;
        bus.lost_clr = clr;
        @(posedge clk);
        model_step(r, lk, clr);
        #1;
        ph = phase_of(q);
        chk("state",      32'(bus.state),      32'(ph));
        chk("rst_core",   32'(bus.rst_core),   32'(ph < 2));
        chk("rst_periph", 32'(bus.rst_periph), 32'(ph != 3));
        chk("ready",      32'(bus.ready),      32'(ph == 3));
        chk("tick",       32'(bus.tick),       32'(m_tick));
        chk("lock_lost",  32'(bus.lock_lost),  32'(m_lost));
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        bus.lost_clr = 1'b0;

        // Power-up with lock low: everything held in reset.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("pwr_core", 32'(bus.rst_core), 32'd1);
            chk("pwr_state", 32'(bus.state), 32'd0);
        end

        // Clean lock: first sampled at edge k=0.
        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("clean_core",  32'(bus.rst_core),   32'(!(k + 1 >= CORE_EDGE)));
            chk("clean_ready", 32'(bus.ready),      32'(k + 1 >= PERIPH_EDGE));
            chk("clean_tick",  32'(bus.tick),       32'((k + 1 == 20) || (k + 1 == 25) || (k + 1 == 30)));
        end

        // Lock loss in RUN, then re-lock; the fault stays sticky.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
        chk("loss_state", 32'(bus.state),     32'd0);
        chk("loss_lost",  32'(bus.lock_lost), 32'd1);
        chk("loss_core",  32'(bus.rst_core),  32'd1);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("loss_notick", 32'(bus.tick), 32'd0);
        end
        for (int k = 0; k < 24; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("relock_ready", 32'(bus.ready),     32'd1);
        chk("relock_lost",  32'(bus.lock_lost), 32'd1);

        // Clear while running, then loss coinciding with clear: set wins, a later clear alone wins.
        cyc(1'b0, 1'b1, 1'b1);
        chk("clr_run", 32'(bus.lock_lost), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_prio_set",   32'(bus.lock_lost), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_prio_clear", 32'(bus.lock_lost), 32'd0);

        // Glitch in STABLE: one-cycle drop sampled at edge 6, re-lock sampled at edge 7.
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 26; k++) begin
            cyc(1'b0, (k != 6), 1'b0);
            if (k >= 7)
                chk("glitch_core", 32'(bus.rst_core), 32'(!(k - 7 + 1 >= CORE_EDGE)));
            chk("glitch_lost", 32'(bus.lock_lost), 32'd0);
        end

        // Reset mid-RUN with lock held: reset values next edge, then a full re-release.
        for (int k = 0; k < 6; k++) cyc(1'b0, (k > 1), 1'b0);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("pre_rst_ready", 32'(bus.ready), 32'd1);
        chk("pre_rst_lost",  32'(bus.lock_lost), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rst_core",  32'(bus.rst_core),  32'd1);
        chk("rst_lost",  32'(bus.lock_lost), 32'd0);
        chk("rst_tick",  32'(bus.tick),      32'd0);
        chk("rst_state", 32'(bus.state),     32'd0);
        for (int k = 0; k < 18; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("rerel_core",  32'(bus.rst_core), 32'(!(k + 1 >= CORE_EDGE)));
            chk("rerel_ready", 32'(bus.ready),    32'(k + 1 >= PERIPH_EDGE));
        end

        // Randomized traffic: long lock runs with occasional drops, clears and resets.
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 44) != 0),
                ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
